// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg -- shared definitions for the UART frame receiver.
//
// Holds the receiver state encoding, the default frame start byte, the
// frame length constants and a helper that folds the four payload bytes
// into the XOR checksum.
//
// Configuration macro: UART_FRAME_CHKSUM_EN (adds a trailing XOR byte).

package uart_frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  localparam int PAYLOAD_BYTES = 4;

`ifdef UART_FRAME_CHKSUM_EN
  localparam int FRAME_LEN = 1 + PAYLOAD_BYTES + 1;
`else
  localparam int FRAME_LEN = 1 + PAYLOAD_BYTES;
`endif

  // XOR of the four payload bytes; the header never takes part.
  function automatic logic [7:0] payload_xor(input logic [31:0] payload);
    return payload[31:24] ^ payload[23:16] ^ payload[15:8] ^ payload[7:0];
  endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if -- byte stream in, frame results out.
//
// Signals:
//   rx_done_tick  one-cycle strobe, rxbus valid in the same cycle
//   rxbus         received byte
//   rx_buf        last accepted 32-bit frame payload
//   frame_valid   one-cycle pulse when rx_buf is updated
//   chk_err       one-cycle pulse on checksum mismatch
//   to_err        one-cycle pulse on inter-byte timeout
//   err_cnt       saturating count of error pulses
//
// Modports: master (byte source / result consumer), slave (the receiver).

interface uart_frame_rx_if;

  logic        rx_done_tick;
  logic [7:0]  rxbus;
  logic [31:0] rx_buf;
  logic        frame_valid;
  logic        chk_err;
  logic        to_err;
  logic [7:0]  err_cnt;

  modport master (
    output rx_done_tick, rxbus,
    input  rx_buf, frame_valid, chk_err, to_err, err_cnt
  );

  modport slave (
    input  rx_done_tick, rxbus,
    output rx_buf, frame_valid, chk_err, to_err, err_cnt
  );

endinterface

// File: rtl/uart_frame_timeout.sv
// uart_frame_timeout -- inter-byte idle watchdog for the frame receiver.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   clear   zero the idle count (byte received, or receiver hunting)
//   enable  count idle cycles while a frame is in progress
//   expire  high in the cycle the count sits at TIMEOUT_CYC-1
//
// TO_W must be wide enough to hold TIMEOUT_CYC-1.

module uart_frame_timeout #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] count_q;

  // The count parks at LAST rather than wrapping so a stalled receiver can
  // never see a second, spurious expiry from a rolled-over counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + TO_W'(1);
    end
  end

  assign expire = enable && (count_q == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx -- hunts for a header byte in a UART byte stream and
// assembles the following four bytes (MSB first) into a 32-bit word.
//
// Ports:
//   clk   system clock, all state changes on its rising edge
//   rst   asynchronous active-low reset
//   bus   uart_frame_rx_if.slave (byte strobe in; rx_buf, frame_valid,
//         chk_err, to_err, err_cnt out)
//
// Parameters: HDR (start byte), TIMEOUT_CYC (idle cycles allowed between
// bytes of a frame), TO_W (timeout counter width).
//
// Configuration macro: UART_FRAME_CHKSUM_EN. When defined, each frame
// carries a trailing XOR byte checked in the CHECK state; otherwise the
// frame is accepted after the fourth payload byte and chk_err is tied low.

module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HDR         = HDR_DEFAULT,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         TO_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_frame_rx_if.slave bus
);

  localparam logic [1:0] LAST_IDX = 2'(PAYLOAD_BYTES - 1);

  state_t      state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] rx_buf_q, rx_buf_d;
  logic        frame_valid_q, frame_valid_d;
  logic        to_err_q, to_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        err_event;
  logic        to_clear, to_enable, to_expire;
`ifdef UART_FRAME_CHKSUM_EN
  logic        chk_err_q, chk_err_d;
`endif

  // The watchdog only runs while a frame is partially received; every
  // byte strobe restarts the idle window.
  assign to_clear  = bus.rx_done_tick || (state_q == HUNT);
  assign to_enable = (state_q != HUNT);

  uart_frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .enable (to_enable),
    .expire (to_expire)
  );

  // Next-state and output decode. A byte strobe is always tested before
  // the timeout so a byte landing in the expiry cycle is kept. All result
  // pulses are registered, which gives the one-cycle accept latency and
  // leaves HUNT free to take a new header in the frame_valid cycle.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    idx_d         = idx_q;
    rx_buf_d      = rx_buf_q;
    frame_valid_d = 1'b0;
    to_err_d      = 1'b0;
    err_cnt_d     = err_cnt_q;
    err_event     = 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
    chk_err_d     = 1'b0;
`endif

    case (state_q)
      HUNT: begin
        if (bus.rx_done_tick && (bus.rxbus == HDR)) begin
          state_d = PAYLOAD;
          idx_d   = '0;
        end
      end

      PAYLOAD: begin
        if (bus.rx_done_tick) begin
          shadow_d = {shadow_q[23:0], bus.rxbus};
          idx_d    = idx_q + 2'd1;
          if (idx_q == LAST_IDX) begin
`ifdef UART_FRAME_CHKSUM_EN
            state_d = CHECK;
`else
            rx_buf_d      = {shadow_q[23:0], bus.rxbus};
            frame_valid_d = 1'b1;
            state_d       = HUNT;
`endif
          end
        end else if (to_expire) begin
          to_err_d = 1'b1;
          state_d  = HUNT;
        end
      end

      CHECK: begin
`ifdef UART_FRAME_CHKSUM_EN
        if (bus.rx_done_tick) begin
          if (bus.rxbus == payload_xor(shadow_q)) begin
            rx_buf_d      = shadow_q;
            frame_valid_d = 1'b1;
          end else begin
            chk_err_d = 1'b1;
          end
          state_d = HUNT;
        end else if (to_expire) begin
          to_err_d = 1'b1;
          state_d  = HUNT;
        end
`else
        state_d = HUNT;
`endif
      end

      default: state_d = HUNT;
    endcase

`ifdef UART_FRAME_CHKSUM_EN
    err_event = to_err_d || chk_err_d;
`else
    err_event = to_err_d;
`endif
    if (err_event && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State register; reset drops any partial frame silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= HUNT;
      shadow_q      <= '0;
      idx_q         <= '0;
      rx_buf_q      <= '0;
      frame_valid_q <= 1'b0;
      to_err_q      <= 1'b0;
      err_cnt_q     <= '0;
`ifdef UART_FRAME_CHKSUM_EN
      chk_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      idx_q         <= idx_d;
      rx_buf_q      <= rx_buf_d;
      frame_valid_q <= frame_valid_d;
      to_err_q      <= to_err_d;
      err_cnt_q     <= err_cnt_d;
`ifdef UART_FRAME_CHKSUM_EN
      chk_err_q     <= chk_err_d;
`endif
    end
  end

  assign bus.rx_buf      = rx_buf_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.to_err      = to_err_q;
  assign bus.err_cnt     = err_cnt_q;
`ifdef UART_FRAME_CHKSUM_EN
  assign bus.chk_err     = chk_err_q;
`else
  assign bus.chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx -- directed self-checking bench for uart_frame_rx.
//
// Drives byte strobes through uart_frame_rx_if on the falling clock edge
// and samples results on the falling edge after the capturing rising edge.
// Works with and without UART_FRAME_CHKSUM_EN defined.

module tb_uart_frame_rx;

  localparam int TO_CYC = 32;
  localparam int TOW    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_frame_rx_if bus ();

  uart_frame_rx #(
    .HDR         (8'hA5),
    .TIMEOUT_CYC (TO_CYC),
    .TO_W        (TOW)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int fv_seen      = 0;
  int chk_seen     = 0;
  int to_seen      = 0;

  // Pulse counters sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.frame_valid === 1'b1) fv_seen++;
    if (bus.chk_err === 1'b1) chk_seen++;
    if (bus.to_err === 1'b1) to_seen++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Caller is at a falling edge; returns at the falling edge after capture.
  task automatic send_byte(input logic [7:0] b);
    bus.rxbus        = b;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  // Header, four payload bytes MSB first, and the checksum byte if enabled.
  task automatic send_frame(input logic [31:0] p, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(p[31:24]);
    send_byte(p[23:16]);
    send_byte(p[15:8]);
    send_byte(p[7:0]);
`ifdef UART_FRAME_CHKSUM_EN
    send_byte(chk);
`else
    if (chk === 8'hxx) $display("[TB] unused checksum byte");
`endif
  endtask

  task automatic test_reset;
    bus.rx_done_tick = 1'b0;
    bus.rxbus        = 8'h00;
    rst_n            = 1'b0;
    idle(3);
    tests_run++;
    if (bus.rx_buf !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rx_buf: got %h expected %h", bus.rx_buf, 32'h0);
    end
    tests_run++;
    if ({bus.frame_valid, bus.chk_err, bus.to_err} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_pulses: got %b expected %b",
               {bus.frame_valid, bus.chk_err, bus.to_err}, 3'b000);
    end
    tests_run++;
    if (bus.err_cnt !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_err_cnt: got %h expected %h", bus.err_cnt, 8'h00);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame;
    int f0;
    f0 = fv_seen;
    send_byte(8'hA5);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
`ifdef UART_FRAME_CHKSUM_EN
    send_byte(8'h78);
    tests_run++;
    if (bus.frame_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL good_early_valid: got %b expected %b", bus.frame_valid, 1'b0);
    end
    send_byte(8'h08);
`else
    tests_run++;
    if (bus.frame_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL good_early_valid: got %b expected %b", bus.frame_valid, 1'b0);
    end
    send_byte(8'h78);
`endif
    tests_run++;
    if (bus.frame_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL good_valid: got %b expected %b", bus.frame_valid, 1'b1);
    end
    tests_run++;
    if (bus.rx_buf !== 32'h12345678) begin
      tests_failed++;
      $display("[TB] FAIL good_rx_buf: got %h expected %h", bus.rx_buf, 32'h12345678);
    end
    idle(1);
    tests_run++;
    if (bus.frame_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL good_valid_drop: got %b expected %b", bus.frame_valid, 1'b0);
    end
    idle(2);
    tests_run++;
    if (fv_seen - f0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL good_pulse_count: got %0d expected %0d", fv_seen - f0, 1);
    end
  endtask

  task automatic test_checksum;
`ifdef UART_FRAME_CHKSUM_EN
    int f0;
    f0 = fv_seen;
    send_frame(32'h12345678, 8'h09);
    tests_run++;
    if (bus.chk_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL chk_err_pulse: got %b expected %b", bus.chk_err, 1'b1);
    end
    tests_run++;
    if (bus.err_cnt !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL chk_err_cnt: got %0d expected %0d", bus.err_cnt, 1);
    end
    send_frame(32'hCAFEBABE, 8'h00);
    tests_run++;
    if (bus.rx_buf !== 32'h12345678) begin
      tests_failed++;
      $display("[TB] FAIL chk_rx_buf_hold: got %h expected %h", bus.rx_buf, 32'h12345678);
    end
    tests_run++;
    if (bus.err_cnt !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL chk_err_cnt2: got %0d expected %0d", bus.err_cnt, 2);
    end
    idle(2);
    tests_run++;
    if (fv_seen - f0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL chk_no_valid: got %0d expected %0d", fv_seen - f0, 0);
    end
    tests_run++;
    if (bus.chk_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL chk_err_drop: got %b expected %b", bus.chk_err, 1'b0);
    end
`else
    send_frame(32'hCAFEBABE, 8'h00);
    send_byte(8'h00);
    idle(2);
    tests_run++;
    if (chk_seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL chk_tied_low: got %0d expected %0d", chk_seen, 0);
    end
    tests_run++;
    if (bus.rx_buf !== 32'hCAFEBABE) begin
      tests_failed++;
      $display("[TB] FAIL nochk_rx_buf: got %h expected %h", bus.rx_buf, 32'hCAFEBABE);
    end
    tests_run++;
    if (bus.err_cnt !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL nochk_err_cnt: got %0d expected %0d", bus.err_cnt, 0);
    end
`endif
  endtask

  task automatic test_hunt_junk;
    int f0;
    logic [7:0] e0;
    logic [7:0] seq [8];
    f0 = fv_seen;
    e0 = bus.err_cnt;
    seq = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hA4};
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    idle(2);
    tests_run++;
    if (bus.rx_buf !== 32'hA5000001) begin
      tests_failed++;
      $display("[TB] FAIL junk_rx_buf: got %h expected %h", bus.rx_buf, 32'hA5000001);
    end
    tests_run++;
    if (fv_seen - f0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL junk_pulse_count: got %0d expected %0d", fv_seen - f0, 1);
    end
    tests_run++;
    if (bus.err_cnt !== e0) begin
      tests_failed++;
      $display("[TB] FAIL junk_err_cnt: got %0d expected %0d", bus.err_cnt, e0);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] e0;
    e0 = bus.err_cnt;
    send_byte(8'hA5);
    send_byte(8'h11);
    idle(TO_CYC - 1);
    tests_run++;
    if (bus.to_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL to_early: got %b expected %b", bus.to_err, 1'b0);
    end
    idle(1);
    tests_run++;
    if (bus.to_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL to_pulse: got %b expected %b", bus.to_err, 1'b1);
    end
    tests_run++;
    if (bus.err_cnt !== e0 + 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL to_err_cnt: got %0d expected %0d", bus.err_cnt, e0 + 8'd1);
    end
    idle(1);
    tests_run++;
    if (bus.to_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL to_drop: got %b expected %b", bus.to_err, 1'b0);
    end
    send_frame(32'hDEADBEEF, 8'h22);
    tests_run++;
    if ({bus.frame_valid, bus.rx_buf} !== {1'b1, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("[TB] FAIL to_recover: got %b/%h expected %b/%h",
               bus.frame_valid, bus.rx_buf, 1'b1, 32'hDEADBEEF);
    end
    idle(1);
  endtask

  task automatic test_timeout_coincide;
    int t0;
    logic [7:0] seq [5];
    t0 = to_seen;
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_byte(8'hA5);
`ifdef UART_FRAME_CHKSUM_EN
    for (int i = 0; i < 5; i++) begin
`else
    for (int i = 0; i < 4; i++) begin
`endif
      idle(TO_CYC - 1);
      send_byte(seq[i]);
    end
    tests_run++;
    if ({bus.frame_valid, bus.rx_buf} !== {1'b1, 32'h01020304}) begin
      tests_failed++;
      $display("[TB] FAIL coincide_frame: got %b/%h expected %b/%h",
               bus.frame_valid, bus.rx_buf, 1'b1, 32'h01020304);
    end
    idle(2);
    tests_run++;
    if (to_seen - t0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL coincide_no_to: got %0d expected %0d", to_seen - t0, 0);
    end
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = fv_seen;
    send_frame(32'h11223344, 8'h44);
    tests_run++;
    if ({bus.frame_valid, bus.rx_buf} !== {1'b1, 32'h11223344}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got %b/%h expected %b/%h",
               bus.frame_valid, bus.rx_buf, 1'b1, 32'h11223344);
    end
    send_frame(32'h55667788, 8'hCC);
    tests_run++;
    if ({bus.frame_valid, bus.rx_buf} !== {1'b1, 32'h55667788}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got %b/%h expected %b/%h",
               bus.frame_valid, bus.rx_buf, 1'b1, 32'h55667788);
    end
    idle(2);
    tests_run++;
    if (fv_seen - f0 !== 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_pulse_count: got %0d expected %0d", fv_seen - f0, 2);
    end
  endtask

  task automatic test_reset_mid_frame;
    int c0, t0;
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    idle(2);
    tests_run++;
    if ({bus.rx_buf, bus.err_cnt, bus.frame_valid, bus.chk_err, bus.to_err} !== 43'h0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_outputs: got %h/%h/%b%b%b expected all zero",
               bus.rx_buf, bus.err_cnt, bus.frame_valid, bus.chk_err, bus.to_err);
    end
    c0 = chk_seen;
    t0 = to_seen;
    rst_n = 1'b1;
    idle(TO_CYC + 5);
    tests_run++;
    if ((chk_seen - c0) + (to_seen - t0) !== 0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_no_error: got %0d expected %0d",
               (chk_seen - c0) + (to_seen - t0), 0);
    end
    send_frame(32'h0BADF00D, 8'h5B);
    tests_run++;
    if ({bus.frame_valid, bus.rx_buf} !== {1'b1, 32'h0BADF00D}) begin
      tests_failed++;
      $display("[TB] FAIL midrst_next_frame: got %b/%h expected %b/%h",
               bus.frame_valid, bus.rx_buf, 1'b1, 32'h0BADF00D);
    end
    idle(1);
  endtask

  task automatic test_saturation;
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 300; i++) begin
`ifdef UART_FRAME_CHKSUM_EN
      send_frame(32'h12345678, 8'h09);
`else
      send_byte(8'hA5);
      idle(TO_CYC + 1);
`endif
      if (i == 99) begin
        tests_run++;
        if (bus.err_cnt !== 8'd100) begin
          tests_failed++;
          $display("[TB] FAIL sat_mid: got %0d expected %0d", bus.err_cnt, 100);
        end
      end
    end
    tests_run++;
    if (bus.err_cnt !== 8'd255) begin
      tests_failed++;
      $display("[TB] FAIL sat_final: got %0d expected %0d", bus.err_cnt, 255);
    end
    send_frame(32'h01020304, 8'h04);
    tests_run++;
    if ({bus.frame_valid, bus.rx_buf} !== {1'b1, 32'h01020304}) begin
      tests_failed++;
      $display("[TB] FAIL sat_then_frame: got %b/%h expected %b/%h",
               bus.frame_valid, bus.rx_buf, 1'b1, 32'h01020304);
    end
    tests_run++;
    if (bus.err_cnt !== 8'd255) begin
      tests_failed++;
      $display("[TB] FAIL sat_hold: got %0d expected %0d", bus.err_cnt, 255);
    end
  endtask

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rxbus        = 8'h00;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_checksum();
    test_hunt_junk();
    test_timeout();
    test_timeout_coincide();
    test_back_to_back();
    test_reset_mid_frame();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
